// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch controller.
// Holds the state encoding, the count width and the default timing constants.
package sw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_t;

    localparam int VAL_W         = 16;
    localparam int CNT_FULL_DEF  = 100_000_000;
    localparam int DB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch controller.
// The master drives the raw buttons; the slave (the controller) drives the rest.
interface stopwatch_ctrl_if;

    logic                     BTN_SS;
    logic                     BTN_CLR;
    logic [sw_pkg::VAL_W-1:0] VAL;
    logic [sw_pkg::VAL_W-1:0] DISP;
    logic                     RUN;
    logic                     TICK;
    logic                     DONE;
    logic                     LAP;

    modport master (
        output BTN_SS, BTN_CLR,
        input  VAL, DISP, RUN, TICK, DONE, LAP
    );

    modport slave (
        input  BTN_SS, BTN_CLR,
        output VAL, DISP, RUN, TICK, DONE, LAP
    );

endinterface

// File: rtl/btn_debounce.sv
// Synchronise and debounce one raw button; PRESS pulses once per accepted press.
// Raw high first sampled to PRESS: DB_CYCLES+3 cycles; no backpressure.
module btn_debounce
    import sw_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic LEVEL,
    output logic PRESS
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_level_q;
    logic            r_press;
    logic [DB_W-1:0] r_db;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_press   <= 1'b0;
            r_db      <= '0;
        end else begin
            r_sync1   <= BTN;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q;
            // Any return to the accepted level restarts the stability window.
            if (r_sync2 != r_level) begin
                if (r_db == DB_LAST) begin
                    r_level <= r_sync2;
                    r_db    <= '0;
                end else begin
                    r_db    <= r_db + 1'b1;
                end
            end else begin
                r_db <= '0;
            end
        end
    end

    assign LEVEL = r_level;
    assign PRESS = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear stopwatch: debounced buttons, tick prescaler, 16-bit count.
// Outputs registered, button to state change DB_CYCLES+4 cycles; lap freeze with STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import sw_pkg::*;
#(
    parameter int               CNT_FULL  = CNT_FULL_DEF,
    parameter int               DB_CYCLES = DB_CYCLES_DEF,
    parameter logic [VAL_W-1:0] VAL_MAX   = 16'hFFFF
) (
    input  logic             CLK,
    input  logic             RST_N,
    stopwatch_ctrl_if.slave  SW
);

    localparam int PRE_W = $clog2(CNT_FULL);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CNT_FULL - 1);

    sw_state_t        r_state;
    logic [VAL_W-1:0] r_val;
    logic [VAL_W-1:0] r_disp;
    logic [PRE_W-1:0] r_pre;
    logic             r_run;
    logic             r_tick;
    logic             r_done;

    logic             w_ss_press;
    logic             w_clr_press;
    logic             w_ss_go;
    logic             w_tick_due;
    logic             w_hit_max;
    logic [VAL_W-1:0] w_val_inc;
    logic [VAL_W-1:0] w_disp_nxt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .CLK   (CLK),
        .RST_N (RST_N),
        .BTN   (SW.BTN_SS),
        .LEVEL (),
        .PRESS (w_ss_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .BTN   (SW.BTN_CLR),
        .LEVEL (),
        .PRESS (w_clr_press)
    );

    // CLR wins a same-cycle collision with SS in every state.
    assign w_ss_go    = w_ss_press & ~w_clr_press;
    assign w_tick_due = (r_state == RUN) && (r_pre == PRE_LAST);
    assign w_val_inc  = r_val + 1'b1;
    assign w_hit_max  = w_tick_due && (w_val_inc == VAL_MAX);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_val   <= '0;
            r_disp  <= '0;
            r_pre   <= '0;
            r_run   <= 1'b0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_disp <= w_disp_nxt;
            case (r_state)
                IDLE: begin
                    if (w_ss_go) begin
                        r_state <= RUN;
                        r_pre   <= '0;
                        r_run   <= 1'b1;
                    end
                end
                RUN: begin
                    // The pausing edge holds PRE so a resume keeps the partial period.
                    if (w_tick_due) begin
                        r_pre  <= '0;
                        r_val  <= w_val_inc;
                        r_tick <= 1'b1;
                    end else if (!w_ss_go) begin
                        r_pre <= r_pre + 1'b1;
                    end
                    if (w_hit_max) begin
                        r_state <= DONE;
                        r_run   <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_ss_go) begin
                        r_state <= PAUSE;
                        r_run   <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (w_clr_press) begin
                        r_state <= IDLE;
                        r_val   <= '0;
                        r_pre   <= '0;
                    end else if (w_ss_go) begin
                        r_state <= RUN;
                        r_run   <= 1'b1;
                    end
                end
                DONE: begin
                    if (w_clr_press) begin
                        r_state <= IDLE;
                        r_val   <= '0;
                        r_pre   <= '0;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic             r_lap;
    logic [VAL_W-1:0] r_lap_val;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_lap     <= 1'b0;
            r_lap_val <= '0;
        end else if (w_clr_press && (r_state == RUN)) begin
            r_lap <= ~r_lap;
            if (!r_lap) begin
                r_lap_val <= r_val;
            end
        end else if (w_clr_press && ((r_state == PAUSE) || (r_state == DONE))) begin
            r_lap     <= 1'b0;
            r_lap_val <= '0;
        end
    end

    assign w_disp_nxt = r_lap ? r_lap_val : r_val;
    assign SW.LAP     = r_lap;
`else
    assign w_disp_nxt = r_val;
    assign SW.LAP     = 1'b0;
`endif

    assign SW.VAL  = r_val;
    assign SW.DISP = r_disp;
    assign SW.RUN  = r_run;
    assign SW.TICK = r_tick;
    assign SW.DONE = r_done;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DB_CYCLES=4, CNT_FULL=10, VAL_MAX=5.
// Expected ticks are queued when a run is started and checked as TICK pulses appear.
module tb_stopwatch_ctrl;

    localparam int DBC = 4;
    localparam int CNT = 10;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        logic [15:0] val;
    } tick_exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int          vectors;
    int          miscompares;
    tick_exp_t   exp_q[$];

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(
        .CNT_FULL  (CNT),
        .DB_CYCLES (DBC),
        .VAL_MAX   (16'd5)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .SW    (sw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic wait_until(input int unsigned n);
        if (cyc > n) chk("schedule_late", cyc, n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic press(input bit ss, input bit clr, input int unsigned hold, output int unsigned m);
        m = cyc;
        sw.BTN_SS  = ss;
        sw.BTN_CLR = clr;
        wait_until(m + hold);
        sw.BTN_SS  = 1'b0;
        sw.BTN_CLR = 1'b0;
    endtask

    task automatic push_tick(input int unsigned c, input logic [15:0] v);
        tick_exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sw.TICK === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("tick_spurious", sw.TICK, 0);
                end else begin
                    tick_exp_t e;
                    e = exp_q.pop_front();
                    chk("tick_cycle", cyc, e.cyc);
                    chk("tick_val", sw.VAL, e.val);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned m, e, t, r;
        vectors     = 0;
        miscompares = 0;
        sw.BTN_SS   = 1'b0;
        sw.BTN_CLR  = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_val", sw.VAL, 0);
        chk("rst_disp", sw.DISP, 0);
        chk("rst_run", sw.RUN, 0);
        chk("rst_tick", sw.TICK, 0);
        chk("rst_done", sw.DONE, 0);
        chk("rst_lap", sw.LAP, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Short glitch must not start the watch.
        press(1'b1, 1'b0, DBC - 1, m);
        wait_until(m + 20);
        chk("glitch_run", sw.RUN, 0);
        chk("glitch_val", sw.VAL, 0);

        // Start: press seen DB_CYCLES+3 after first sample, RUN one cycle later.
        press(1'b1, 1'b0, 8, m);
        chk("start_run_early", sw.RUN, 0);
        wait_until(m + DBC + 5);
        chk("start_run", sw.RUN, 1);
        e = m + DBC + 5;
        for (int i = 1; i <= 4; i++) push_tick(e + CNT * i, 16'(i));
        wait_until(e + 35);
        chk("count_val3", sw.VAL, 3);
        chk("count_disp3", sw.DISP, 3);

        // Pause with PRE=6, then resume: tick after the remaining 4 cycles.
        wait_until(e + 38);
        press(1'b1, 1'b0, 8, m);
        t = m + DBC + 5;
        wait_until(t);
        chk("pause_run", sw.RUN, 0);
        chk("pause_val", sw.VAL, 4);
        wait_until(t + 50);
        chk("pause_hold_val", sw.VAL, 4);
        press(1'b1, 1'b0, 8, m);
        r = m + DBC + 5;
        push_tick(r + 4, 16'd5);
        wait_until(r);
        chk("resume_run", sw.RUN, 1);
        wait_until(r + 4);
        chk("autostop_done", sw.DONE, 1);
        chk("autostop_run", sw.RUN, 0);
        chk("autostop_val", sw.VAL, 5);
        wait_until(r + 34);
        chk("done_hold_val", sw.VAL, 5);

        press(1'b1, 1'b0, 8, m);
        wait_until(m + 20);
        chk("done_ss_ignored", sw.DONE, 1);
        chk("done_ss_val", sw.VAL, 5);
        press(1'b0, 1'b1, 8, m);
        wait_until(m + DBC + 5);
        chk("done_clr_done", sw.DONE, 0);
        chk("done_clr_val", sw.VAL, 0);
        chk("done_clr_run", sw.RUN, 0);
        wait_until(m + DBC + 6);
        chk("done_clr_disp", sw.DISP, 0);
        wait_until(m + 20);

        // Lap toggle in RUN (no effect when the lap feature is absent).
        press(1'b1, 1'b0, 8, m);
        e = m + DBC + 5;
        for (int i = 1; i <= 5; i++) push_tick(e + CNT * i, 16'(i));
        wait_until(e);
        chk("lap_start_run", sw.RUN, 1);
        wait_until(e + 16);
        press(1'b0, 1'b1, 8, m);
        wait_until(e + 25);
        chk("lap_on", sw.LAP, 32'(LAP_ON));
        wait_until(e + 37);
        press(1'b0, 1'b1, 8, m);
        chk("lap_val4", sw.VAL, 4);
        chk("lap_disp_frozen", sw.DISP, LAP_ON ? 32'd2 : 32'd4);
        wait_until(e + 46);
        chk("lap_off", sw.LAP, 0);
        wait_until(e + 47);
        chk("lap_disp_back", sw.DISP, 4);
        wait_until(e + 50);
        chk("lap_run_done", sw.DONE, 1);
        wait_until(e + 60);
        press(1'b0, 1'b1, 8, m);
        wait_until(m + DBC + 5);
        chk("lap_clr_val", sw.VAL, 0);
        chk("lap_clr_lap", sw.LAP, 0);
        wait_until(m + 20);

        // Both buttons together in PAUSE: clear wins, no restart.
        press(1'b1, 1'b0, 8, m);
        e = m + DBC + 5;
        push_tick(e + CNT, 16'd1);
        push_tick(e + 2 * CNT, 16'd2);
        wait_until(e + 15);
        press(1'b1, 1'b0, 8, m);
        t = m + DBC + 5;
        wait_until(t);
        chk("both_pause_run", sw.RUN, 0);
        chk("both_pause_val", sw.VAL, 2);
        wait_until(t + 10);
        press(1'b1, 1'b1, 8, m);
        wait_until(m + DBC + 5);
        chk("both_val", sw.VAL, 0);
        chk("both_run", sw.RUN, 0);
        chk("both_done", sw.DONE, 0);
        wait_until(m + 30);
        chk("both_no_restart", sw.RUN, 0);

        // Reset in the middle of a run discards everything.
        press(1'b1, 1'b0, 8, m);
        e = m + DBC + 5;
        push_tick(e + CNT, 16'd1);
        wait_until(e + 15);
        rst_n = 1'b0;
        wait_until(e + 16);
        chk("mid_rst_val", sw.VAL, 0);
        chk("mid_rst_disp", sw.DISP, 0);
        chk("mid_rst_run", sw.RUN, 0);
        chk("mid_rst_tick", sw.TICK, 0);
        chk("mid_rst_done", sw.DONE, 0);
        chk("mid_rst_lap", sw.LAP, 0);
        rst_n = 1'b1;
        wait_until(e + 40);
        chk("post_rst_val", sw.VAL, 0);
        chk("post_rst_run", sw.RUN, 0);
        chk("ticks_outstanding", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control front-end for the team's 1-Hz up-counter datapath. Debounces two push-buttons, runs a start/pause/clear state machine and owns the tick prescaler and the 16-bit elapsed-count register.
- Sits between the board buttons and the 7-seg display driver.
- DISP feeds the display. VAL is the live count.

Parameters:
- CNT_FULL, 100_000_000: clock cycles per count tick (≥2).
- DB_CYCLES, 1_000_000: consecutive stable cycles before a button level change is accepted (≥1).
- VAL_MAX, 16'hFFFF: count value at which the block auto-stops.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  synchronous reset, active-low.
- BTN_SS  in  1  raw start/stop button, asynchronous, active-high.
- BTN_CLR  in  1  raw clear/lap button, asynchronous, active-high.
- VAL  out  16  live elapsed count.
- DISP  out  16  value for the display: VAL, or the frozen lap value.
- RUN  out  1  high while in state RUN.
- TICK  out  1  one-cycle pulse on each count increment.
- DONE  out  1  high while in state DONE.
- LAP  out  1  high while the lap freeze is active.

Behaviour:
- Reset: RST_N low at a rising edge clears everything.
  - State → IDLE; VAL, DISP, prescaler PRE, lap register, debounce counters, sync flops and debounced levels all → 0.
  - RUN, TICK, DONE, LAP → 0.
  - Reset mid-run discards all progress.
- Debounce, per button:
  - 2-flop synchronizer, then counter DB.
  - DB increments while the synced level ≠ debounced level; otherwise DB resets to 0.
  - When DB reaches DB_CYCLES: debounced level takes the synced level, DB → 0.
  - Press event = one-cycle pulse on the debounced 0→1 edge.
  - Latency from the raw level first sampled high to the event pulse: DB_CYCLES+3 cycles.
  - Glitches shorter than DB_CYCLES are ignored. Release generates no event.
- States: IDLE, RUN, PAUSE, DONE. Outputs are registered.
  - IDLE: SS event → RUN with PRE=0. CLR event ignored.
  - RUN: PRE counts 0..CNT_FULL-1.
    - When PRE==CNT_FULL-1: PRE → 0, VAL+1, TICK=1 on the same edge.
    - If the increment makes VAL==VAL_MAX → DONE; no further increment and no wrap.
    - SS event → PAUSE; PRE is held so a resume keeps the fractional period.
  - PAUSE: SS event → RUN, PRE resumes. CLR event → IDLE; VAL, PRE and lap all cleared.
  - DONE: VAL held at VAL_MAX. SS event ignored. CLR event → IDLE with everything cleared.
- Simultaneous SS and CLR events in the same cycle: CLR is processed and SS is dropped, in every state.
- A tick and an SS event in the same cycle in RUN: the increment happens and the state goes to PAUSE.
- DISP equals VAL one cycle later (registered), except while LAP=1.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - In RUN, a CLR event toggles LAP.
  - LAP 0→1 latches the current VAL into the lap register; DISP shows the lap register while VAL keeps counting.
  - LAP 1→0 returns DISP to VAL.
  - Leaving RUN by SS keeps the LAP state.
  - A CLR in PAUSE or DONE clears LAP together with everything else.
- Undefined:
  - CLR events in RUN are ignored; LAP is tied to 0.
  - DISP always tracks VAL; no lap register is synthesized.

Decomposition:
- Shared package sw_pkg holds:
  - state typedef (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3);
  - VAL_W=16;
  - the default CNT_FULL and DB_CYCLES constants.
- One sub-module, btn_debounce (parameter DB_CYCLES; ports CLK, RST_N, BTN, LEVEL, PRESS), instantiated twice.
- The prescaler and state machine stay in stopwatch_ctrl.

Test Plan (DB_CYCLES=4, CNT_FULL=10, VAL_MAX=5 unless noted):
- Debounce: raw BTN_SS high 3 cycles then low → no event, state IDLE. Raw BTN_SS held high → PRESS pulse exactly 7 cycles after first sampled high, RUN=1 the next cycle.
- Counting: start, then run 35 cycles → VAL=3, three TICK pulses spaced 10 cycles apart, DISP=3.
- Pause/resume: pause at PRE=6 and wait 50 cycles → VAL unchanged. Resume → next TICK 4 cycles after re-entering RUN.
- Auto-stop: run to VAL=5 → DONE=1, RUN=0, VAL stays 5. SS press ignored. CLR press → IDLE, VAL=0, DONE=0.
- Simultaneous press in PAUSE with VAL=2: both buttons pressed → IDLE, VAL=0, state not RUN. Mid-run RST_N=0 for 1 cycle → all outputs 0 at the next edge.
- With STOPWATCH_LAP_EN: CLR in RUN at VAL=2 → LAP=1, DISP held at 2 while VAL reaches 4. Second CLR → DISP=4, LAP=0. Without the macro: same stimulus → LAP=0, DISP tracks VAL.
